// File: rtl/csi_pixel_capture.sv
// csi_pixel_capture: DVP byte stream to RGB565 FIFO writer.
// Frame aligned, with line/frame checking and overflow status.
module csi_pixel_capture #(
    parameter int H_PIXELS  = 480,
    parameter int V_LINES   = 272,
    parameter int VSYNC_POL = 1,
    parameter int CNT_W     = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CSI_VSYNC,
    input  logic             CSI_HREF,
    input  logic [7:0]       CSI_D,
    input  logic             FIFO_FULL,
    output logic [15:0]      FIFO_DI,
    output logic             FIFO_WE,
    output logic             FRAME_DONE,
    output logic             FRAME_OK,
    output logic             LINE_ERR,
    output logic             OVERFLOW,
    output logic [CNT_W-1:0] LINE_CNT,
    output logic             CAPTURING
);

    typedef enum logic [1:0] {
        SYNC,
        BLANK,
        SKIP,
        CAPTURE
    } state_t;

    state_t state, state_nxt;

    logic             phase;
    logic [7:0]       hi_byte;
    logic [CNT_W-1:0] pix_cnt;
    logic             href_q;
    logic             frame_err;

    logic             vs_act;
    logic             cap;
    logic             take;
    logic             pix_done;
    logic             line_end;
    logic             line_bad;
    logic             frame_end;
    logic             start;
    logic [CNT_W-1:0] lc_inc;
    logic [CNT_W-1:0] lc_now;
    logic             err_now;

    assign vs_act    = (CSI_VSYNC == 1'(VSYNC_POL));
    assign cap       = (state == CAPTURE);
    assign CAPTURING = cap;

    // Datapath strobes; a line also ends when VSYNC cuts it short.
    always_comb begin
        take      = cap && CSI_HREF && !vs_act;
        pix_done  = take && phase;
        line_end  = cap && href_q && (!CSI_HREF || vs_act);
        line_bad  = phase || (pix_cnt != CNT_W'(H_PIXELS));
        frame_end = cap && vs_act;
        start     = (state == BLANK) && !vs_act && EN;
        lc_inc    = (&LINE_CNT) ? LINE_CNT : LINE_CNT + 1'b1;
        lc_now    = line_end ? lc_inc : LINE_CNT;
        err_now   = frame_err || (line_end && line_bad);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= SYNC;
        else     state <= state_nxt;
    end

    // Next-state: SYNC skips the partial frame seen after reset.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SYNC:    if (vs_act)  state_nxt = BLANK;
            BLANK:   if (!vs_act) state_nxt = EN ? CAPTURE : SKIP;
            SKIP:    if (vs_act)  state_nxt = BLANK;
            CAPTURE: if (vs_act)  state_nxt = BLANK;
            default: state_nxt = SYNC;
        endcase
    end

    // Byte packing, FIFO writes, line/frame accounting and status.
    always_ff @(posedge CLK) begin
        if (RST) begin
            FIFO_DI    <= '0;
            FIFO_WE    <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_OK   <= 1'b0;
            LINE_ERR   <= 1'b0;
            OVERFLOW   <= 1'b0;
            LINE_CNT   <= '0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            pix_cnt    <= '0;
            href_q     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            FIFO_WE    <= pix_done && !FIFO_FULL;
            FRAME_DONE <= frame_end;
            FRAME_OK   <= frame_end && !err_now &&
                          (lc_now == CNT_W'(V_LINES));
            href_q     <= cap && CSI_HREF;
            if (pix_done && !FIFO_FULL) FIFO_DI <= {hi_byte, CSI_D};
            if (pix_done && FIFO_FULL)  OVERFLOW <= 1'b1;
            if (take && !phase)         hi_byte <= CSI_D;
            if (!cap || line_end) begin
                phase   <= 1'b0;
                pix_cnt <= '0;
            end else if (take) begin
                phase <= ~phase;
                if (phase && !(&pix_cnt)) pix_cnt <= pix_cnt + 1'b1;
            end
            if (start) begin
                LINE_CNT  <= '0;
                frame_err <= 1'b0;
            end else if (line_end) begin
                LINE_CNT <= lc_inc;
                if (line_bad) begin
                    LINE_ERR  <= 1'b1;
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_csi_pixel_capture.sv
// tb_csi_pixel_capture: directed bench, reduced frame size.
// 4 pixels (8 bytes) per line, 3 lines per frame.
module tb_csi_pixel_capture;

    localparam int HP = 4;
    localparam int VL = 3;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          RST, EN, VSYNC, HREF, FULL;
    logic [7:0]    D;
    logic [15:0]   FIFO_DI;
    logic          FIFO_WE, FRAME_DONE, FRAME_OK;
    logic          LINE_ERR, OVERFLOW, CAPTURING;
    logic [CW-1:0] LINE_CNT;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int ok_last = 0;
    int lc_last = 0;
    int w0, d0;

    csi_pixel_capture #(
        .H_PIXELS (HP),
        .V_LINES  (VL),
        .VSYNC_POL(1),
        .CNT_W    (CW)
    ) dut (
        .CLK       (clk),
        .RST       (RST),
        .EN        (EN),
        .CSI_VSYNC (VSYNC),
        .CSI_HREF  (HREF),
        .CSI_D     (D),
        .FIFO_FULL (FULL),
        .FIFO_DI   (FIFO_DI),
        .FIFO_WE   (FIFO_WE),
        .FRAME_DONE(FRAME_DONE),
        .FRAME_OK  (FRAME_OK),
        .LINE_ERR  (LINE_ERR),
        .OVERFLOW  (OVERFLOW),
        .LINE_CNT  (LINE_CNT),
        .CAPTURING (CAPTURING)
    );

    always #5 clk = ~clk;

    // Record write strobes and the frame-done status.
    always @(negedge clk) begin
        if (FIFO_WE) we_cnt++;
        if (FRAME_DONE) begin
            done_cnt++;
            ok_last = int'(FRAME_OK);
            lc_last = int'(LINE_CNT);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        HREF  = 1'b0;
        VSYNC = 1'b1;
        repeat (2) tick();
        VSYNC = 1'b0;
        repeat (2) tick();
    endtask

    // FULL is held over both bytes of pixels flo..fhi.
    task automatic send_line(input int nb, input int flo, input int fhi);
        for (int b = 0; b < nb; b++) begin
            HREF = 1'b1;
            D    = 8'(b * 17 + 3);
            FULL = (b / 2 >= flo) && (b / 2 <= fhi);
            tick();
        end
        HREF = 1'b0;
        FULL = 1'b0;
        repeat (2) tick();
    endtask

    task automatic send_frame();
        for (int l = 0; l < VL; l++) send_line(2 * HP, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; EN = 1'b1; VSYNC = 1'b0;
        HREF = 1'b0; FULL = 1'b0; D = 8'h00;
        repeat (3) tick();
        chk("rst_we", int'(FIFO_WE), 0);
        chk("rst_di", int'(FIFO_DI), 0);
        chk("rst_done", int'(FRAME_DONE), 0);
        chk("rst_ok", int'(FRAME_OK), 0);
        chk("rst_lerr", int'(LINE_ERR), 0);
        chk("rst_ovf", int'(OVERFLOW), 0);
        chk("rst_lcnt", int'(LINE_CNT), 0);
        chk("rst_cap", int'(CAPTURING), 0);
        RST = 1'b0;

        send_frame();
        chk("sync_writes", we_cnt, 0);
        chk("sync_cap", int'(CAPTURING), 0);
        vsync_pulse();
        chk("sync_done", done_cnt, 0);

        w0 = we_cnt;
        send_frame();
        chk("f1_cap", int'(CAPTURING), 1);
        chk("f1_lcnt", int'(LINE_CNT), 3);
        vsync_pulse();
        chk("f1_writes", we_cnt - w0, 12);
        chk("f1_done", done_cnt, 1);
        chk("f1_ok", ok_last, 1);
        chk("f1_lc", lc_last, 3);

        w0 = we_cnt;
        HREF = 1'b1;
        D = 8'hF8; tick();
        chk("px_we_lo", int'(FIFO_WE), 0);
        D = 8'h1F; tick();
        chk("px_we", int'(FIFO_WE), 1);
        chk("px_di", int'(FIFO_DI), 16'hF81F);
        D = 8'h12; tick();
        chk("px_we_1cyc", int'(FIFO_WE), 0);
        chk("px_di_hold", int'(FIFO_DI), 16'hF81F);
        for (int b = 0; b < 5; b++) begin
            D = 8'(b); tick();
        end
        HREF = 1'b0;
        repeat (2) tick();
        send_line(2 * HP, 1, 0);
        send_line(2 * HP, 1, 0);
        vsync_pulse();
        chk("f2_writes", we_cnt - w0, 12);
        chk("f2_ok", ok_last, 1);

        w0 = we_cnt;
        send_line(2 * HP, 1, 0);
        send_line(2 * HP, 1, 2);
        send_line(2 * HP, 1, 0);
        vsync_pulse();
        chk("ovf_writes", we_cnt - w0, 10);
        chk("ovf_flag", int'(OVERFLOW), 1);
        chk("ovf_lerr", int'(LINE_ERR), 0);
        chk("ovf_ok", ok_last, 1);

        w0 = we_cnt;
        send_line(2 * HP, 1, 0);
        send_line(2 * HP + 1, 1, 0);
        send_line(2 * HP, 1, 0);
        vsync_pulse();
        chk("odd_writes", we_cnt - w0, 12);
        chk("odd_lerr", int'(LINE_ERR), 1);
        chk("odd_ok", ok_last, 0);
        chk("odd_ovf_sticky", int'(OVERFLOW), 1);

        w0 = we_cnt;
        send_frame();
        EN = 1'b0;
        vsync_pulse();
        chk("clean_writes", we_cnt - w0, 12);
        chk("clean_ok", ok_last, 1);
        chk("clean_lerr", int'(LINE_ERR), 1);

        w0 = we_cnt;
        d0 = done_cnt;
        EN = 1'b1;
        send_frame();
        chk("skip_cap", int'(CAPTURING), 0);
        vsync_pulse();
        chk("skip_writes", we_cnt - w0, 0);
        chk("skip_done", done_cnt - d0, 0);

        w0 = we_cnt;
        send_frame();
        vsync_pulse();
        chk("resume_writes", we_cnt - w0, 12);
        chk("resume_done", done_cnt - d0, 1);
        chk("resume_ok", ok_last, 1);

        send_line(2 * HP, 1, 0);
        send_line(2 * HP, 1, 0);
        vsync_pulse();
        chk("short_ok", ok_last, 0);
        chk("short_lc", lc_last, 2);

        w0 = we_cnt;
        HREF = 1'b1;
        for (int b = 0; b < 3; b++) begin
            D = 8'(b + 40); tick();
        end
        D = 8'h55;
        RST = 1'b1;
        tick();
        chk("mrst_we", int'(FIFO_WE), 0);
        chk("mrst_cap", int'(CAPTURING), 0);
        RST = 1'b0;
        HREF = 1'b0;
        repeat (2) tick();
        w0 = we_cnt;
        send_line(2 * HP, 1, 0);
        send_line(2 * HP, 1, 0);
        chk("mrst_nowrite", we_cnt - w0, 0);
        vsync_pulse();
        w0 = we_cnt;
        send_frame();
        vsync_pulse();
        chk("mrst_writes", we_cnt - w0, 12);
        chk("mrst_ok", ok_last, 1);
        chk("mrst_ovf", int'(OVERFLOW), 0);
        chk("mrst_lerr", int'(LINE_ERR), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
